// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared APB definitions used by the requester and the completer blocks.
//   ADDR_WIDTH  : default APB address width
//   DATA_WIDTH  : default APB data width
//   ALIGNBITS   : number of low address bits that must be zero (word access)
//   req_state_t : requester FSM states
//   validAlign(): 1 when an address is word aligned
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ALIGNBITS  = 2;

  typedef enum logic [1:0] {
    REQ_IDLE   = 2'd0,
    REQ_SETUP  = 2'd1,
    REQ_ACCESS = 2'd2,
    REQ_RESP   = 2'd3
  } req_state_t;

  // Mask of the address bits that must be zero for a legal access.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ADDR_WIDTH'((32'd1 << ALIGNBITS) - 32'd1);

  function automatic logic validAlign(input logic [ADDR_WIDTH-1:0] addr);
    return ((addr & ALIGN_MASK) == {ADDR_WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/apb_requester_if.sv
// -----------------------------------------------------------------------------
// apb_requester_if
// Bundles the command channel, the response channel and the APB bus of the
// requester.
//   master modport : requester view (drives cmd_ready, rsp_*, psel/penable/
//                    pwrite/paddr/pwdata; samples cmd_*, rsp_ready, prdata,
//                    pready, pslverr)
//   slave modport  : environment view (command source, response sink and
//                    APB completer)
// -----------------------------------------------------------------------------
interface apb_requester_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = apb_pkg::DATA_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_requester.sv
// -----------------------------------------------------------------------------
// apb_requester
// APB3 manager: turns one valid/ready command into one APB transfer (SETUP,
// then ACCESS with any number of wait states) and holds the result on the
// response channel until it is consumed. Misaligned addresses are answered
// locally with an error and never reach the bus.
//
// Ports:
//   pclk    : APB clock
//   presetn : asynchronous active-low reset
//   bus     : apb_requester_if.master (command, response and APB signals)
//
// Configuration macro:
//   APB_REQ_TIMEOUT_EN : when defined, an ACCESS phase that sees pready low
//                        for TIMEOUT_CYCLES cycles is aborted with rsp_err=1.
// -----------------------------------------------------------------------------
module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = apb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  apb_requester_if.master    bus
);

  req_state_t            state_r;
  logic                  psel_r;
  logic                  penable_r;
  logic                  pwrite_r;
  logic [ADDR_WIDTH-1:0] paddr_r;
  logic [DATA_WIDTH-1:0] pwdata_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic                  rsp_err_r;

`ifdef APB_REQ_TIMEOUT_EN
  localparam logic [7:0] TLIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] tcnt_r;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES == 32'sd0);
`endif

  assign bus.cmd_ready = (state_r == REQ_IDLE);
  assign bus.psel      = psel_r;
  assign bus.penable   = penable_r;
  assign bus.pwrite    = pwrite_r;
  assign bus.paddr     = paddr_r;
  assign bus.pwdata    = pwdata_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;

  // Transfer sequencer: owns the FSM, all APB outputs and the response registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r     <= REQ_IDLE;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= {ADDR_WIDTH{1'b0}};
      pwdata_r    <= {DATA_WIDTH{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
      tcnt_r      <= 8'd0;
`endif
    end else begin
      case (state_r)
        REQ_IDLE: begin
          // cmd_ready is high in this state, so cmd_valid alone means accept.
          if (bus.cmd_valid) begin
            if (validAlign(bus.cmd_addr)) begin
              paddr_r   <= bus.cmd_addr;
              pwrite_r  <= bus.cmd_write;
              pwdata_r  <= bus.cmd_wdata;
              psel_r    <= 1'b1;
              penable_r <= 1'b0;
              state_r   <= REQ_SETUP;
            end else begin
              // Rejected locally: the bus is never touched.
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= {DATA_WIDTH{1'b0}};
              rsp_valid_r <= 1'b1;
              state_r     <= REQ_RESP;
            end
          end
        end
        REQ_SETUP: begin
          penable_r <= 1'b1;
          state_r   <= REQ_ACCESS;
`ifdef APB_REQ_TIMEOUT_EN
          tcnt_r    <= 8'd0;
`endif
        end
        REQ_ACCESS: begin
          if (bus.pready) begin
            rsp_err_r   <= bus.pslverr;
            rsp_rdata_r <= (!pwrite_r && !bus.pslverr) ? bus.prdata
                                                       : {DATA_WIDTH{1'b0}};
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= REQ_RESP;
          end else begin
`ifdef APB_REQ_TIMEOUT_EN
            // This cycle is the TIMEOUT_CYCLES-th wait state: give up.
            if (tcnt_r + 8'd1 == TLIMIT) begin
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= {DATA_WIDTH{1'b0}};
              psel_r      <= 1'b0;
              penable_r   <= 1'b0;
              rsp_valid_r <= 1'b1;
              state_r     <= REQ_RESP;
            end else begin
              tcnt_r <= tcnt_r + 8'd1;
            end
`else
            // Wait state: every APB output holds its value.
            state_r <= REQ_ACCESS;
`endif
          end
        end
        REQ_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= REQ_IDLE;
          end
        end
        default: begin
          state_r     <= REQ_IDLE;
          psel_r      <= 1'b0;
          penable_r   <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// -----------------------------------------------------------------------------
// tb_apb_requester
// Randomized bench for apb_requester. A stimulus process issues commands and
// pushes the expected response (and expected bus transfer) into queues; a
// response monitor and a bus monitor pop and compare independently. A small
// APB completer model inserts the wait states and errors chosen per command.
// -----------------------------------------------------------------------------
module tb_apb_requester;

  localparam int TO_CYC = 4;
`ifdef APB_REQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  logic pclk;
  logic presetn;

  apb_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus.master)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t  rsp_q[$];
  xfer_t bus_q[$];

  int          cur_waits = 0;
  logic        cur_err   = 1'b0;
  logic [31:0] cur_rdata = 32'd0;
  bit          hold_rsp  = 1'b0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    checks++;
    failures++;
    $display("FAIL %s %s at cycle %0d", name, msg, cyc);
  endtask

  // Completer model: wait states, read data and error for the current transfer.
  int wcnt = 0;
  always @(negedge pclk) begin
    if (bus.psel && bus.penable) begin
      if (wcnt < cur_waits) begin
        bus.pready = 1'b0;
        wcnt++;
      end else begin
        bus.pready  = 1'b1;
        bus.prdata  = cur_rdata;
        bus.pslverr = cur_err;
      end
    end else begin
      bus.pready  = 1'b0;
      bus.pslverr = 1'($urandom_range(0, 1));
      bus.prdata  = $urandom;
      wcnt        = 0;
    end
  end

  // Response consumer: random backpressure, or none accepted while held.
  always @(posedge pclk) begin
    #1;
    bus.rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Response monitor.
  bit rsp_seen = 1'b0;
  always @(negedge pclk) begin
    if (!presetn) begin
      rsp_seen = 1'b0;
    end else if (bus.rsp_valid) begin
      if (rsp_q.size() == 0) begin
        fail_now("rsp_unexpected", "response with nothing outstanding");
      end else begin
        if (!rsp_seen) begin
          chk("rsp_latency", 32'(cyc - rsp_q[0].acc), 32'(rsp_q[0].lat));
          rsp_seen = 1'b1;
        end
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, rsp_q[0].err});
        chk("rsp_rdata", bus.rsp_rdata, rsp_q[0].rdata);
        chk("cmd_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
        if (bus.rsp_ready) begin
          void'(rsp_q.pop_front());
          rsp_seen = 1'b0;
        end
      end
    end
  end

  // Bus monitor: address phase contents and SETUP->ACCESS ordering.
  bit prev_psel  = 1'b0;
  bit prev_setup = 1'b0;
  always @(negedge pclk) begin
    if (!presetn) begin
      prev_psel  = 1'b0;
      prev_setup = 1'b0;
    end else begin
      if (bus.psel) begin
        if (bus_q.size() == 0) begin
          fail_now("psel_unexpected", "psel with no aligned command");
        end else begin
          chk("paddr", bus.paddr, bus_q[0].a);
          chk("pwrite", {31'd0, bus.pwrite}, {31'd0, bus_q[0].w});
          chk("pwdata", bus.pwdata, bus_q[0].d);
          if (prev_setup) chk("penable_after_setup", {31'd0, bus.penable}, 32'd1);
        end
      end
      if (prev_psel && !bus.psel && bus_q.size() > 0) void'(bus_q.pop_front());
      prev_psel  = bus.psel;
      prev_setup = bus.psel && !bus.penable;
    end
  end

  // Issue one command; returns just after it has been accepted.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int waits, input logic serr, input logic [31:0] rd);
    int    n;
    bit    al;
    bit    to;
    exp_t  e;
    xfer_t x;
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    n = 0;
    while (!bus.cmd_ready && n < 300) begin
      @(negedge pclk);
      n++;
    end
    if (!bus.cmd_ready) begin
      fail_now("cmd_accept_timeout", "cmd_ready never rose");
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge pclk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    cur_waits = waits;
    cur_err   = serr;
    cur_rdata = rd;
    // Reference model of the expected outcome.
    al = ((a % 4) == 0);
    to = TO_EN && (waits >= TO_CYC);
    e.acc   = cyc;
    e.err   = !al || to || serr;
    e.rdata = (al && !to && !w && !serr) ? rd : 32'd0;
    e.lat   = !al ? 0 : (to ? 1 + TO_CYC : 2 + waits);
    rsp_q.push_back(e);
    if (al) begin
      x.w = w;
      x.a = a;
      x.d = d;
      bus_q.push_back(x);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 500) begin
      @(negedge pclk);
      n++;
    end
    if (rsp_q.size() != 0) fail_now("drain_timeout", "response never consumed");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int          n;
    logic [31:0] held_rdata;
    logic [31:0] a;
    presetn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'd0;
    bus.cmd_wdata = 32'd0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = 32'd0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    #1;
    chk("rst_psel", {31'd0, bus.psel}, 32'd0);
    chk("rst_penable", {31'd0, bus.penable}, 32'd0);
    chk("rst_pwrite", {31'd0, bus.pwrite}, 32'd0);
    chk("rst_paddr", bus.paddr, 32'd0);
    chk("rst_pwdata", bus.pwdata, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    repeat (3) @(negedge pclk);
    presetn = 1'b1;

    // Directed cases.
    issue(1'b0, 32'h8, 32'h0, 0, 1'b0, 32'hDEADBEEF);
    drain();
    issue(1'b1, 32'h4, 32'h12345678, 3, 1'b0, 32'hCAFEF00D);
    drain();
    issue(1'b0, 32'hC, 32'h0, 0, 1'b1, 32'hFFFFFFFF);
    drain();
    issue(1'b0, 32'h6, 32'h0, 0, 1'b0, 32'h11111111);
    drain();

    // Response backpressure: held response must stay put, no new command.
    hold_rsp = 1'b1;
    @(posedge pclk);
    #2;
    issue(1'b0, 32'h10, 32'h0, 1, 1'b0, 32'hA5A5C3C3);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge pclk);
      n++;
    end
    held_rdata = bus.rsp_rdata;
    repeat (4) begin
      @(negedge pclk);
      chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      chk("bp_rdata_stable", bus.rsp_rdata, 32'hA5A5C3C3);
    end
    hold_rsp = 1'b0;
    drain();

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      issue(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3),
            ($urandom_range(0, 4) == 0), $urandom);
    end
    drain();

`ifdef APB_REQ_TIMEOUT_EN
    // Completer never answers: the transfer must be aborted.
    issue(1'b0, 32'h30, 32'h0, 1000, 1'b0, 32'h12121212);
    drain();
`endif

    // Reset in the middle of ACCESS.
    issue(1'b1, 32'h20, 32'h55AA55AA, 1000, 1'b0, 32'h0);
    @(posedge pclk);
    @(posedge pclk);
    #3;
    chk("pre_rst_penable", {31'd0, bus.penable}, 32'd1);
    presetn = 1'b0;
    #1;
    chk("async_rst_psel", {31'd0, bus.psel}, 32'd0);
    chk("async_rst_penable", {31'd0, bus.penable}, 32'd0);
    chk("async_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    rsp_q.delete();
    bus_q.delete();
    cur_waits = 0;
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    issue(1'b0, 32'h24, 32'h0, 2, 1'b0, 32'h0BADF00D);
    drain();

    repeat (3) @(negedge pclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB3 manager (requester) that converts a simple valid/ready command channel into single APB transfers and returns each result on a response channel.
- It is the initiating end that drives the team's APB completer blocks. It also provides the stimulus-side master for the peripheral bench.
- Handles one transfer at a time: SETUP phase, ACCESS phase with unbounded wait states, a registered response held until consumed, and local rejection of misaligned addresses.

Parameters:
- ADDR_WIDTH, default apb_pkg::ADDR_WIDTH; paddr/cmd_addr width.
- DATA_WIDTH, default 32; pwdata/prdata/cmd_wdata/rsp_rdata width.
- TIMEOUT_CYCLES, default 16; maximum ACCESS cycles before abort. Used only when APB_REQ_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- pclk  in  1  APB clock, single clock domain.
- presetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  requester can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  slave error, misalignment, or timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  completer ready.
- pslverr  in  1  completer error.

Behaviour:
- Clock and reset: one clock, pclk. presetn is asynchronous and active-low.
- Reset values (all immediate on presetn low, including mid-transfer): state REQ_IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0; rsp_valid=0, rsp_rdata=0, rsp_err=0; timeout counter 0.
- All APB outputs and response outputs are registered.
- cmd_ready = (state==REQ_IDLE), combinational from state only. A command is accepted on a pclk edge where cmd_valid && cmd_ready.
- States (req_state_t): REQ_IDLE, REQ_SETUP, REQ_ACCESS, REQ_RESP.
- REQ_IDLE:
  - On accept with cmd_addr[ALIGNBITS-1:0]==0: latch paddr/pwrite/pwdata from the command, set psel=1, penable=0, go to REQ_SETUP.
  - On accept with a misaligned address: no bus activity (psel stays 0); go to REQ_RESP with rsp_err=1, rsp_rdata=0.
- REQ_SETUP: lasts exactly one cycle. Set penable=1, go to REQ_ACCESS. paddr/pwrite/pwdata stay stable through SETUP and ACCESS.
- REQ_ACCESS: on a pclk edge with pready=1:
  - Capture rsp_err=pslverr.
  - Capture rsp_rdata = prdata if read and pslverr=0, else 0.
  - Set psel=0, penable=0, rsp_valid=1, go to REQ_RESP.
  - pready=0 holds all APB outputs unchanged (wait state).
- REQ_RESP: rsp_valid=1, rsp_rdata and rsp_err held stable. On an edge with rsp_ready=1: rsp_valid=0, go to REQ_IDLE.
- No pipelining: the next command is accepted no earlier than the cycle after the response handshake.
- Latency, zero wait states: command accepted at edge N; psel=1 after N; penable=1 after N+1; completion at N+2; rsp_valid=1 after N+2.
- Each wait state adds one cycle.
- Misaligned latency: rsp_valid=1 after edge N.
- pwdata retains its last value after the transfer; there is no requirement to clear it.
- rsp_rdata and rsp_err change only when a transfer completes.

Optional Feature:
- Macro: APB_REQ_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering REQ_ACCESS and increments on each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES with pready still 0: set psel=0, penable=0, rsp_err=1, rsp_rdata=0, go to REQ_RESP.
  - pready=1 on the same edge as the limit is reached wins; that transfer completes normally.
- Undefined: no counter logic is present, and ACCESS waits for pready indefinitely.

Decomposition:
- apb_pkg additions:
  - req_state_t enum (REQ_IDLE, REQ_SETUP, REQ_ACCESS, REQ_RESP).
  - DATA_WIDTH constant.
  - Reuse the existing ADDR_WIDTH, ALIGNBITS and validAlign().
- Single module, no sub-module. An apb_requester_timeout counter module is not warranted at this size.

Test Plan:
- Read, zero wait states: cmd read addr 0x8, prdata=0xDEADBEEF with pready=1 in ACCESS. Expected: psel at N+1, penable at N+2, rsp_valid at N+3 with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write with 3 wait states: cmd write addr 0x4, data 0x12345678, pready low for 3 ACCESS cycles. Expected: paddr/pwdata stable for all 5 bus cycles, rsp_valid 3 cycles later than the zero-wait case, rsp_rdata=0.
- Slave error: read addr 0xC with pslverr=1 and prdata=0xFFFFFFFF. Expected: rsp_err=1, rsp_rdata=0.
- Misaligned address: cmd addr 0x6. Expected: psel never asserts, rsp_valid one cycle after accept, rsp_err=1; cmd_ready=0 until the response handshake.
- Response backpressure plus reset: rsp_ready held 0 for 4 cycles, rsp fields stable, cmd_ready=0. Then presetn low mid-ACCESS on a new transfer. Expected: psel/penable/rsp_valid go to 0 immediately, and after release cmd_ready=1.
- Timeout, built with APB_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=4: pready held 0. Expected: psel drops after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0.
